// File: rtl/mux_8x1_rr_arbiter_if.sv
// Handshake bundle between the eight requesters and the arbitrated 8:1 mux.
// req/in come from requesters; grant/sel/valid/out go back to them and downstream.
interface mux_8x1_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       out;

  modport master (
    output req, in,
    input  grant, sel, valid, out
  );

  modport slave (
    input  req, in,
    output grant, sel, valid, out
  );
endinterface

// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin arbiter driving a shared 8:1 one-bit mux, with bounded hold.
// Ports: clk, rst (sync, active-high), bus (slave: req,in -> grant,sel,valid,out).
module mux_8x1 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);
  assign out = in[sel];
endmodule

module mux_8x1_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_8x1_rr_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  // Saturation point of the hold counter; all-ones when hold is unlimited.
  localparam logic [HOLD_W-1:0] HMAX =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  state_t            state;
  logic [7:0]        grant_q;
  logic [2:0]        sel_q;
  logic              valid_q;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              mux_o;

  // Returns {found, index} of the first set bit scanning up from start.
  // Scanning downward lets the nearest hit overwrite farther ones.
  function automatic logic [3:0] pick(
    input logic [7:0] r,
    input logic [2:0] start
  );
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] nxt;
  logic [3:0] idle_p;
  logic [3:0] rel_p;
  logic [3:0] exp_p;
  logic       others;
  logic       expire;

  always_comb begin
    nxt    = sel_q + 3'd1;
    idle_p = pick(bus.req, ptr);
    rel_p  = pick(bus.req, nxt);
    exp_p  = pick(bus.req & ~grant_q, nxt);
    others = |(bus.req & ~grant_q);
    expire = (MAX_HOLD != 0) && (hold_cnt == HMAX) && others;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= 8'd0;
      sel_q    <= 3'd0;
      valid_q  <= 1'b0;
      ptr      <= 3'd0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (idle_p[3]) begin
            state    <= GRANT;
            grant_q  <= 8'd1 << idle_p[2:0];
            sel_q    <= idle_p[2:0];
            valid_q  <= 1'b1;
            hold_cnt <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (!bus.req[sel_q]) begin
            ptr <= nxt;
            if (rel_p[3]) begin
              grant_q  <= 8'd1 << rel_p[2:0];
              sel_q    <= rel_p[2:0];
              hold_cnt <= HOLD_W'(1);
            end else begin
              state    <= IDLE;
              grant_q  <= 8'd0;
              valid_q  <= 1'b0;
              hold_cnt <= '0;
            end
          end else if (expire) begin
            ptr      <= nxt;
            grant_q  <= 8'd1 << exp_p[2:0];
            sel_q    <= exp_p[2:0];
            hold_cnt <= HOLD_W'(1);
          end else if (hold_cnt != HMAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux_8x1 u_mux (
    .in  (bus.in),
    .sel (sel_q),
    .out (mux_o)
  );

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.out   = valid_q & mux_o;
endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// Scoreboard bench for mux_8x1_rr_arbiter.
// Expected grant/sel/valid/out are queued at drive time and checked after the edge.
module tb_mux_8x1_rr_arbiter;
  logic clk;
  logic rst;

  mux_8x1_rr_arbiter_if bus ();

  mux_8x1_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       o;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic push_exp(input logic [7:0] g, input logic [2:0] s,
                          input logic v);
    exp_t e;
    logic [7:0] d;
    d = bus.in;
    e.g = g;
    e.s = s;
    e.v = v;
    e.o = v & d[s];
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.req = 8'hFF;
    bus.in = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      push_exp(8'h00, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if ({bus.grant, bus.sel, bus.valid, bus.out} !== {e.g, e.s, e.v, e.o}) begin
        bad++;
        $display("FAIL reset[%0d] got g=%h s=%0d v=%b o=%b want g=%h s=%0d v=%b o=%b",
                 i, bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, e.v, e.o);
      end
    end
  endtask

  task automatic test_grant();
    exp_t e;
    rst = 1'b0;
    bus.req = 8'h08;
    bus.in = 8'h08;
    push_exp(8'h08, 3'd3, 1'b1);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    total++;
    if ({bus.grant, bus.sel, bus.valid, bus.out} !== {e.g, e.s, e.v, e.o}) begin
      bad++;
      $display("FAIL grant got g=%h s=%0d v=%b o=%b want g=%h s=%0d v=%b o=%b",
               bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, e.v, e.o);
    end
    bus.in = 8'h00;
    #1;
    total++;
    if (bus.out !== 1'b0) begin
      bad++;
      $display("FAIL comb_out got o=%b want o=0", bus.out);
    end
    bus.req = 8'h00;
    push_exp(8'h00, 3'd3, 1'b0);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    total++;
    if ({bus.grant, bus.sel, bus.valid, bus.out} !== {e.g, e.s, e.v, e.o}) begin
      bad++;
      $display("FAIL grant_idle got g=%h s=%0d v=%b o=%b want g=%h s=%0d v=%b o=%b",
               bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, e.v, e.o);
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    logic [2:0] idx;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      bus.req = 8'hFF;
      bus.in = 8'($urandom);
      idx = 3'((c / 4) % 8);
      push_exp(8'd1 << idx, idx, 1'b1);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if ({bus.grant, bus.sel, bus.valid, bus.out} !== {e.g, e.s, e.v, e.o}) begin
        bad++;
        $display("FAIL rotation[%0d] got g=%h s=%0d v=%b o=%b want g=%h s=%0d v=%b o=%b",
                 c, bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, e.v, e.o);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] rq [3] = '{8'h22, 8'h20, 8'h00};
    logic [7:0] eg [3] = '{8'h02, 8'h20, 8'h00};
    logic [2:0] es [3] = '{3'd1, 3'd5, 3'd5};
    logic       ev [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req = rq[i];
      bus.in = 8'($urandom);
      push_exp(eg[i], es[i], ev[i]);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if ({bus.grant, bus.sel, bus.valid, bus.out} !== {e.g, e.s, e.v, e.o}) begin
        bad++;
        $display("FAIL back_to_back[%0d] got g=%h s=%0d v=%b o=%b want g=%h s=%0d v=%b o=%b",
                 i, bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, e.v, e.o);
      end
    end
  endtask

  task automatic test_wrap_sole();
    exp_t e;
    logic [7:0] rq [4] = '{8'h80, 8'h81, 8'h01, 8'h04};
    logic [7:0] eg [4] = '{8'h80, 8'h80, 8'h01, 8'h04};
    logic [2:0] es [4] = '{3'd7, 3'd7, 3'd0, 3'd2};
    do_reset();
    for (int i = 0; i < 24; i++) begin
      bus.req = (i < 4) ? rq[i] : 8'h04;
      bus.in = 8'($urandom);
      push_exp((i < 4) ? eg[i] : 8'h04, (i < 4) ? es[i] : 3'd2, 1'b1);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if ({bus.grant, bus.sel, bus.valid, bus.out} !== {e.g, e.s, e.v, e.o}) begin
        bad++;
        $display("FAIL wrap_sole[%0d] got g=%h s=%0d v=%b o=%b want g=%h s=%0d v=%b o=%b",
                 i, bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, e.v, e.o);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic       rs [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] rq [3] = '{8'h10, 8'h10, 8'h11};
    logic [7:0] eg [3] = '{8'h10, 8'h00, 8'h01};
    logic [2:0] es [3] = '{3'd4, 3'd0, 3'd0};
    logic       ev [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rst = rs[i];
      bus.req = rq[i];
      bus.in = 8'($urandom);
      push_exp(eg[i], es[i], ev[i]);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if ({bus.grant, bus.sel, bus.valid, bus.out} !== {e.g, e.s, e.v, e.o}) begin
        bad++;
        $display("FAIL mid_reset[%0d] got g=%h s=%0d v=%b o=%b want g=%h s=%0d v=%b o=%b",
                 i, bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, e.v, e.o);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 8'h00;
    bus.in = 8'h00;
    #1;
    test_reset();
    test_grant();
    test_rotation();
    test_back_to_back();
    test_wrap_sole();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
